// File: rtl/led_pkg.sv
// Shared rate encodings and divider math for the LED clock generator and its users.
package led_pkg;

  localparam logic [1:0] RATE_1HZ = 2'd0;
  localparam logic [1:0] RATE_2HZ = 2'd1;
  localparam logic [1:0] RATE_4HZ = 2'd2;
  localparam logic [1:0] RATE_8HZ = 2'd3;

  // Half-period in system clocks; each rate step halves it.
  function automatic int half_period(input int clk_freq, input logic [1:0] rate);
    return clk_freq >> (int'(rate) + 1);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Button conditioner: 2-FF synchroniser, stability debounce, one-cycle press pulse.
module key_debounce #(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n_i,
  output logic press_o
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic [1:0]    sync_q;
  logic          ks;
  logic          db_q, db_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

  assign ks = sync_q[1];

  always_comb begin
    db_d    = db_q;
    cnt_d   = cnt_q;
    if (ks == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DB_CYCLES - 1)) begin
      db_d  = ks;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    // Only the falling (pressed) edge of the debounced key is an event.
    press_d = db_q & ~db_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= 2'b11;
      db_q    <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], key_n_i};
      db_q    <= db_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/led_clk_gen.sv
// Button-steppable 1/2/4/8 Hz square-wave generator; rate changes land only
// on the high->low boundary so the downstream stage never sees a runt phase.
module led_clk_gen
  import led_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_n,
  output logic       clk_out,
  output logic       tick,
  output logic [1:0] rate_sel
);

  localparam int CW = $clog2(CLK_FREQ / 2);

  logic          press;
  logic [CW-1:0] cnt_q, cnt_d, last;
  logic          clk_q, clk_d;
  logic          tick_q, tick_d;
  logic [1:0]    rate_q, rate_d;
  logic [1:0]    pend_q, pend_d;
  logic          wrap;

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_key (
    .clk     (clk),
    .rst     (rst),
    .key_n_i (key_n),
    .press_o (press)
  );

  // HALF-1 always fits in CW bits since HALF <= CLK_FREQ/2.
  assign last = CW'(half_period(CLK_FREQ, rate_q) - 1);
  assign wrap = (cnt_q == last);

  always_comb begin
    cnt_d  = wrap ? '0 : cnt_q + CW'(1);
    clk_d  = wrap ? ~clk_q : clk_q;
    tick_d = wrap & ~clk_q;
    rate_d = rate_q;
    pend_d = pend_q;
    // The pending value seen here predates any same-cycle press.
    if (wrap && clk_q) rate_d = pend_q;
    if (press) pend_d = (pend_q == RATE_8HZ) ? RATE_1HZ : pend_q + 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
      rate_q <= RATE_1HZ;
      pend_q <= RATE_1HZ;
    end else begin
      cnt_q  <= cnt_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
      rate_q <= rate_d;
      pend_q <= pend_d;
    end
  end

  assign clk_out  = clk_q;
  assign tick     = tick_q;
  assign rate_sel = rate_q;

endmodule

// File: tb/tb_led_clk_gen.sv
// Self-checking bench for led_clk_gen with an event-level reference model.
module tb_led_clk_gen;
  import led_pkg::*;

  localparam int CF = 16;
  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       key_n = 1'b1;
  logic       clk_out, tick;
  logic [1:0] rate_sel;

  led_clk_gen #(.CLK_FREQ(CF), .DB_CYCLES(DB)) dut (
    .clk      (clk),
    .rst      (rst),
    .key_n    (key_n),
    .clk_out  (clk_out),
    .tick     (tick),
    .rate_sel (rate_sel)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: the output toggles are scheduled as absolute edge numbers,
  // and the key is accepted once the last DB synchronised samples all disagree
  // with the debounced level.
  bit m_k1, m_k2, m_db, m_press, m_clk, m_tick;
  int m_pend, m_rate, m_n, m_next;
  bit hist[$];

  task automatic model_reset();
    m_k1 = 1; m_k2 = 1; m_db = 1; m_press = 0;
    m_clk = 0; m_tick = 0; m_pend = 0; m_rate = 0;
    m_n = 0; m_next = CF >> 1;
    hist.delete();
  endtask

  task automatic model_edge(input bit k);
    bit ks, ndb, all_eq;
    ks = m_k2; m_k2 = m_k1; m_k1 = k;
    hist.push_back(ks);
    if (hist.size() > DB) void'(hist.pop_front());
    all_eq = (hist.size() == DB);
    foreach (hist[i]) if (hist[i] != ks) all_eq = 0;
    ndb = (all_eq && ks != m_db) ? ks : m_db;
    m_n++;
    m_tick = 0;
    if (m_n == m_next) begin
      if (m_clk) begin
        m_clk  = 0;
        m_rate = m_pend;
      end else begin
        m_clk  = 1;
        m_tick = 1;
      end
      m_next = m_n + (CF >> (m_rate + 1));
    end
    if (m_press) m_pend = (m_pend + 1) % 4;
    m_press = m_db && !ndb;
    m_db = ndb;
  endtask

  task automatic step(input bit k);
    key_n = k;
    @(posedge clk);
    model_edge(k);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; key_n = 1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst = 0;
  endtask

  task automatic test_reset();
    #2 rst = 1;
    #1;
    total++;
    if ({clk_out, tick, rate_sel} !== 4'b0000) begin
      bad++; $display("FAIL reset: got %b want 0000", {clk_out, tick, rate_sel});
    end
    do_reset();
  endtask

  task automatic test_idle();
    int first_rise = -1;
    for (int i = 1; i <= 60; i++) begin
      step(1);
      total++;
      if ({clk_out, tick, rate_sel} !== {m_clk, m_tick, 2'(m_rate)}) begin
        bad++; $display("FAIL idle cyc%0d: got %b want %b", i, {clk_out, tick, rate_sel}, {m_clk, m_tick, 2'(m_rate)});
      end
      if (clk_out && first_rise < 0) first_rise = i;
    end
    total++;
    if (first_rise != 8) begin
      bad++; $display("FAIL idle_first_rise: got %0d want 8", first_rise);
    end
  endtask

  task automatic test_glitch();
    for (int i = 0; i < 30; i++) begin
      step(i < 3 ? 1'b0 : 1'b1);
      total++;
      if ({clk_out, tick, rate_sel} !== {m_clk, m_tick, 2'(m_rate)}) begin
        bad++; $display("FAIL glitch cyc%0d: got %b want %b", i, {clk_out, tick, rate_sel}, {m_clk, m_tick, 2'(m_rate)});
      end
    end
    total++;
    if (rate_sel !== RATE_1HZ) begin
      bad++; $display("FAIL glitch_rate: got %0d want %0d", rate_sel, RATE_1HZ);
    end
  endtask

  task automatic wait_level(input bit lvl, input string nm);
    bit seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      step(1);
      total++;
      if ({clk_out, tick, rate_sel} !== {m_clk, m_tick, 2'(m_rate)}) begin
        bad++; $display("FAIL %s_wait: got %b want %b", nm, {clk_out, tick, rate_sel}, {m_clk, m_tick, 2'(m_rate)});
      end
      if (clk_out === lvl) seen = 1;
    end
    if (!seen) begin
      total++; bad++; $display("FAIL %s_timeout: got no clk_out=%0d want it within 100 cycles", nm, lvl);
    end
  endtask

  task automatic test_press_high();
    int hi = 1;
    wait_level(0, "ph_low");
    wait_level(1, "ph_rise");
    for (int i = 0; i < 20; i++) begin
      step(i < 6 ? 1'b0 : 1'b1);
      total++;
      if ({clk_out, tick, rate_sel} !== {m_clk, m_tick, 2'(m_rate)}) begin
        bad++; $display("FAIL press_high cyc%0d: got %b want %b", i, {clk_out, tick, rate_sel}, {m_clk, m_tick, 2'(m_rate)});
      end
      if (clk_out) hi++;
      else break;
    end
    total++;
    if (hi != 8) begin
      bad++; $display("FAIL press_high_len: got %0d want 8", hi);
    end
    total++;
    if (rate_sel !== RATE_2HZ) begin
      bad++; $display("FAIL press_high_rate: got %0d want %0d", rate_sel, RATE_2HZ);
    end
    for (int i = 0; i < 24; i++) begin
      step(1);
      total++;
      if ({clk_out, tick, rate_sel} !== {m_clk, m_tick, 2'(m_rate)}) begin
        bad++; $display("FAIL rate1_run cyc%0d: got %b want %b", i, {clk_out, tick, rate_sel}, {m_clk, m_tick, 2'(m_rate)});
      end
    end
  endtask

  task automatic test_double();
    do_reset();
    wait_level(1, "dbl_rise");
    wait_level(0, "dbl_fall");
    for (int i = 0; i < 40; i++) begin
      step((i < 4 || (i >= 8 && i < 12)) ? 1'b0 : 1'b1);
      total++;
      if ({clk_out, tick, rate_sel} !== {m_clk, m_tick, 2'(m_rate)}) begin
        bad++; $display("FAIL double cyc%0d: got %b want %b", i, {clk_out, tick, rate_sel}, {m_clk, m_tick, 2'(m_rate)});
      end
    end
    total++;
    if (rate_sel !== RATE_4HZ) begin
      bad++; $display("FAIL double_rate: got %0d want %0d", rate_sel, RATE_4HZ);
    end
  endtask

  task automatic test_reset_mid();
    wait_level(1, "mid_rise");
    #2 rst = 1;
    #1;
    total++;
    if ({clk_out, tick, rate_sel} !== 4'b0000) begin
      bad++; $display("FAIL reset_mid: got %b want 0000", {clk_out, tick, rate_sel});
    end
    do_reset();
    test_idle();
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 3 * 11 + 40; i++) begin
      step((i < 33 && (i % 11) < 5) ? 1'b0 : 1'b1);
      total++;
      if ({clk_out, tick, rate_sel} !== {m_clk, m_tick, 2'(m_rate)}) begin
        bad++; $display("FAIL wrap_up cyc%0d: got %b want %b", i, {clk_out, tick, rate_sel}, {m_clk, m_tick, 2'(m_rate)});
      end
    end
    total++;
    if (rate_sel !== RATE_8HZ) begin
      bad++; $display("FAIL wrap_at3: got %0d want %0d", rate_sel, RATE_8HZ);
    end
    for (int i = 0; i < 50; i++) begin
      step(i < 5 ? 1'b0 : 1'b1);
      total++;
      if ({clk_out, tick, rate_sel} !== {m_clk, m_tick, 2'(m_rate)}) begin
        bad++; $display("FAIL wrap cyc%0d: got %b want %b", i, {clk_out, tick, rate_sel}, {m_clk, m_tick, 2'(m_rate)});
      end
    end
    total++;
    if (rate_sel !== RATE_1HZ) begin
      bad++; $display("FAIL wrap_to0: got %0d want %0d", rate_sel, RATE_1HZ);
    end
  endtask

  task automatic test_random();
    int left = 0;
    bit kv = 1;
    for (int i = 0; i < 1500; i++) begin
      if (left == 0) begin
        kv = ~kv;
        left = $urandom_range(1, 9);
      end
      left--;
      step(kv);
      total++;
      if ({clk_out, tick, rate_sel} !== {m_clk, m_tick, 2'(m_rate)}) begin
        bad++; $display("FAIL random cyc%0d: got %b want %b", i, {clk_out, tick, rate_sel}, {m_clk, m_tick, 2'(m_rate)});
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_glitch();
    test_press_high();
    test_double();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
